// File: rtl/ha_carry_resolver.sv
// Resolves a half-adder array's per-bit (sum, cout) vectors into a binary total,
// propagating one carry step per clock behind valid/ready handshakes.
module ha_carry_resolver #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_sum,
  input  logic [N-1:0] in_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_result,
  output logic [7:0]   out_iters,
  output logic         out_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [N:0]   s, c;
  logic [7:0]   iters;
  logic         ovf;

  logic [N:0]   s_nxt, c_nxt;
  logic [7:0]   iters_nxt;
  logic         ovf_nxt;

  // One carry-propagation step; the carry out of bit N is dropped and flagged.
  always_comb begin
    s_nxt     = s ^ c;
    c_nxt     = (s & c) << 1;
    iters_nxt = (iters == 8'hFF) ? iters : iters + 8'd1;
    ovf_nxt   = ovf | (s[N] & c[N]);
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s          <= '0;
      c          <= '0;
      iters      <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_iters  <= '0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s     <= {1'b0, in_sum};
            c     <= {in_cout, 1'b0};
            iters <= '0;
            ovf   <= 1'b0;
            // With no carries the sum vector already is the answer.
            if (in_cout == '0) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= {1'b0, in_sum};
              out_iters  <= '0;
              out_ovf    <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          s     <= s_nxt;
          c     <= c_nxt;
          iters <= iters_nxt;
          ovf   <= ovf_nxt;
          if (c_nxt == '0) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= s_nxt;
            out_iters  <= iters_nxt;
            out_ovf    <= ovf_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_carry_resolver.sv
// Self-checking bench for ha_carry_resolver: directed cases, random traffic against an
// arithmetic reference model, output stall, back-to-back and reset-abort scenarios.
module tb_ha_carry_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sum;
  logic [7:0] in_cout;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_result;
  logic [7:0] out_iters;
  logic       out_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ha_carry_resolver #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_cout    (in_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_iters  (out_iters),
    .out_ovf    (out_ovf)
  );

  // Total is sum + 2*cout; iterations counted by adding the two words without carry
  // until no carry remains, on plain integers modulo 512.
  function automatic void model(input logic [7:0] sm, input logic [7:0] cm,
                                output logic [8:0] res, output int it, output bit ov);
    int total, s, c, t;
    total = int'(sm) + 2 * int'(cm);
    res   = 9'(total % 512);
    ov    = (total >= 512);
    s     = int'(sm);
    c     = 2 * int'(cm);
    it    = 0;
    while (c != 0 && it < 100) begin
      t  = s ^ c;
      c  = ((s & c) * 2) % 512;
      s  = t;
      it = it + 1;
    end
  endfunction

  // Drives one transaction, holds out_ready low for 'stall' cycles once valid, then
  // completes the handshake. Latency counts cycles from accept to out_valid, starting at 1.
  task automatic do_txn(input logic [7:0] sm, input logic [7:0] cm, input int stall,
                        output logic [8:0] res, output logic [7:0] it, output logic ov,
                        output int lat, output bit ok);
    int guard;
    ok    = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      return;
    end
    in_valid = 1'b1;
    in_sum   = sm;
    in_cout  = cm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      ok = 1'b0;
      return;
    end
    res = out_result;
    it  = out_iters;
    ov  = out_ovf;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, out_result, out_iters, out_ovf} !== 19'd0) begin
      $display("[TB] FAIL reset_outputs: got v=%b r=%h i=%0d o=%b, want all 0",
               out_valid, out_result, out_iters, out_ovf);
      fails++;
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
      fails++;
    end
  endtask

  task automatic test_directed();
    logic [7:0] sums [5]  = '{8'hCF, 8'h00, 8'h5A, 8'hFF, 8'hFF};
    logic [7:0] couts [5] = '{8'h20, 8'hFF, 8'h00, 8'h01, 8'hFF};
    logic [8:0] exp_r [5] = '{9'h10F, 9'h1FE, 9'h05A, 9'h101, 9'h0FD};
    int         exp_i [5] = '{3, 1, 0, 8, 2};
    bit         exp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [8:0] r;
    logic [7:0] it;
    logic       ov;
    int         lat;
    bit         ok;
    for (int i = 0; i < 5; i++) begin
      do_txn(sums[i], couts[i], 0, r, it, ov, lat, ok);
      tests++;
      if (!ok) begin
        $display("[TB] FAIL directed%0d_timeout: handshake not reached, want completion", i);
        fails++;
        continue;
      end
      tests++;
      if (r !== exp_r[i] || int'(it) != exp_i[i] || ov !== exp_o[i]) begin
        $display("[TB] FAIL directed%0d: got r=%h i=%0d o=%b, want r=%h i=%0d o=%b",
                 i, r, it, ov, exp_r[i], exp_i[i], exp_o[i]);
        fails++;
      end
      tests++;
      if (lat != exp_i[i] + 1) begin
        $display("[TB] FAIL directed%0d_latency: got %0d want %0d", i, lat, exp_i[i] + 1);
        fails++;
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] sm, cm;
    logic [8:0] r, er;
    logic [7:0] it;
    logic       ov;
    int         ei, lat;
    bit         eo, ok;
    for (int n = 0; n < 40; n++) begin
      sm = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       cm = 8'h00;
        1, 2:    cm = 8'($urandom) & ~sm;
        default: cm = 8'($urandom);
      endcase
      model(sm, cm, er, ei, eo);
      do_txn(sm, cm, $urandom_range(0, 2), r, it, ov, lat, ok);
      tests++;
      if (!ok || r !== er || int'(it) != ei || ov !== eo || lat != ei + 1) begin
        $display("[TB] FAIL random%0d sum=%h cout=%h: got r=%h i=%0d o=%b lat=%0d ok=%b, want r=%h i=%0d o=%b lat=%0d",
                 n, sm, cm, r, it, ov, lat, ok, er, ei, eo, ei + 1);
        fails++;
      end
    end
  endtask

  task automatic test_stall();
    logic [8:0] r;
    logic [7:0] it;
    logic       ov;
    int         guard;
    bit         bad;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_sum   = 8'hCF;
    in_cout  = 8'h20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    tests++;
    if (out_valid !== 1'b1 || out_result !== 9'h10F) begin
      $display("[TB] FAIL stall_entry: got v=%b r=%h, want v=1 r=10f", out_valid, out_result);
      fails++;
    end
    r   = out_result;
    it  = out_iters;
    ov  = out_ovf;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_sum   = 8'($urandom);
      in_cout  = 8'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== r ||
          out_iters !== it || out_ovf !== ov)
        bad = 1'b1;
    end
    in_valid = 1'b0;
    tests++;
    if (bad) begin
      $display("[TB] FAIL stall_hold: got v=%b rdy=%b r=%h i=%0d, want v=1 rdy=0 r=%h i=%0d",
               out_valid, in_ready, out_result, out_iters, r, it);
      fails++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("[TB] FAIL stall_release: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] r;
    logic [7:0] it;
    logic       ov;
    int         lat;
    bit         ok;
    do_txn(8'h5A, 8'h00, 0, r, it, ov, lat, ok);
    tests++;
    if (in_ready !== 1'b1) begin
      $display("[TB] FAIL b2b_ready: got %b want 1 right after handshake", in_ready);
      fails++;
    end
    do_txn(8'h0F, 8'h01, 0, r, it, ov, lat, ok);
    tests++;
    if (!ok || r !== 9'h011 || it !== 8'd4 || ov !== 1'b0 || lat != 5) begin
      $display("[TB] FAIL b2b_second: got r=%h i=%0d o=%b lat=%0d, want r=011 i=4 o=0 lat=5",
               r, it, ov, lat);
      fails++;
    end
  endtask

  task automatic test_reset_abort();
    bit pulsed;
    in_valid = 1'b1;
    in_sum   = 8'hFF;
    in_cout  = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      $display("[TB] FAIL abort_running: got v=%b rdy=%b, want v=0 rdy=0", out_valid, in_ready);
      fails++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || {out_valid, out_result, out_iters, out_ovf} !== 19'd0) begin
      $display("[TB] FAIL abort_state: got rdy=%b v=%b r=%h i=%0d o=%b, want rdy=1 rest 0",
               in_ready, out_valid, out_result, out_iters, out_ovf);
      fails++;
    end
    pulsed = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) pulsed = 1'b1;
    end
    tests++;
    if (pulsed) begin
      $display("[TB] FAIL abort_no_valid: got out_valid=1 after abort, want 0");
      fails++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_cout   = '0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
